// File: rtl/posit_sum_normalizer_pkg.sv
// posit_sum_normalizer_pkg
//   Shared types for the posit post-add normalization stage.
//   sign_t        : result sign (POS/NEG)
//   norm_state_t  : normalizer FSM states
//   regime_min()  : most negative value of a signed regime of width w
package posit_sum_normalizer_pkg;

   typedef enum logic {
      POS = 1'b0,
      NEG = 1'b1
   } sign_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } norm_state_t;

   function automatic int regime_min(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/posit_sum_normalizer_exp_dec.sv
// posit_exp_dec
//   Combinational borrow unit on the {regime, exponent} pair; the pair is
//   treated as one scale value regime*2^EN + exponent, decremented by one.
//   regime_in  : signed regime
//   exp_in     : signed exponent; any value <= 0 borrows from the regime
//   regime_out : regime after the decrement
//   exp_out    : exponent after the decrement
//   sat        : regime already at its minimum and a borrow was needed;
//                outputs saturate to {min, 0}
module posit_exp_dec
   import posit_sum_normalizer_pkg::*;
#(
   parameter int EN    = 1,
   parameter int W_REG = 3,
   parameter int W_EXP = 3
) (
   input  logic signed [W_REG-1:0] regime_in,
   input  logic signed [W_EXP-1:0] exp_in,
   output logic signed [W_REG-1:0] regime_out,
   output logic signed [W_EXP-1:0] exp_out,
   output logic                    sat
);

   localparam logic signed [W_REG-1:0] REG_MIN = W_REG'(regime_min(W_REG));
   localparam logic signed [W_EXP-1:0] EXP_TOP = W_EXP'((1 << EN) - 1);

   logic exp_pos;

   // strictly positive: sign bit clear and not zero
   assign exp_pos = !exp_in[W_EXP-1] && (exp_in != '0);

   always_comb begin
      regime_out = regime_in;
      exp_out    = exp_in;
      sat        = 1'b0;
      if (exp_pos) begin
         exp_out = exp_in - W_EXP'(1);
      end else if (regime_in == REG_MIN) begin
         sat     = 1'b1;
         exp_out = '0;
      end else begin
         // borrow: exp_in + 2^EN - 1 covers both the shift case (exp 0 ->
         // top) and the capture fixup, where the caller passes exp+1
         regime_out = regime_in - W_REG'(1);
         exp_out    = exp_in + EXP_TOP;
      end
   end

endmodule

// File: rtl/posit_sum_normalizer.sv
// posit_sum_normalizer
//   Post-add normalization: left-shifts the mantissa sum one bit per cycle
//   until the hidden bit is set, borrowing from exponent/regime on each shift.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : upstream handshake (ready only while IDLE)
//   in_mantissa          : mantissa sum, hidden bit at [W_MAN-1]
//   in_regime            : signed interim regime
//   in_exponent          : signed interim exponent (may be negative)
//   in_negate            : result sign from the adder
//   out_valid / out_ready: downstream handshake
//   out_sign, out_regime, out_exponent, out_mantissa : normalized fields
//   out_zero             : exact zero result
//   out_underflow        : regime hit its minimum before normalization finished
module posit_sum_normalizer
   import posit_sum_normalizer_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int EN    = 1,
   parameter int W_REG = $clog2(WIDTH),
   parameter int W_EXP = $clog2(WIDTH),
   parameter int W_MAN = WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [W_MAN-1:0]        in_mantissa,
   input  logic signed [W_REG-1:0] in_regime,
   input  logic signed [W_EXP-1:0] in_exponent,
   input  logic                    in_negate,
   output logic                    out_valid,
   input  logic                    out_ready,
   output sign_t                   out_sign,
   output logic signed [W_REG-1:0] out_regime,
   output logic signed [W_EXP-1:0] out_exponent,
   output logic [W_MAN-1:0]        out_mantissa,
   output logic                    out_zero,
   output logic                    out_underflow
);

   norm_state_t state, state_nxt;

   // working copy of the operand while normalizing
   logic [W_MAN-1:0]        w_man;
   logic signed [W_REG-1:0] w_reg;
   logic signed [W_EXP-1:0] w_exp;
   logic                    w_neg;
   logic                    w_zero;
   logic                    w_uflow;

   logic signed [W_REG-1:0] dec_reg_in, dec_reg_out;
   logic signed [W_EXP-1:0] dec_exp_in, dec_exp_out;
   logic                    dec_sat;

   logic man_zero, man_norm;

   assign man_zero = (w_man == '0);
   assign man_norm = w_man[W_MAN-1];
   assign in_ready = (state == IDLE);

   // One borrow unit shared by both uses: in IDLE it canonicalizes a
   // negative incoming exponent (fed exp+1 so the result is exp+2^EN),
   // in NORM it supplies the post-shift pair.
   always_comb begin
      dec_reg_in = w_reg;
      dec_exp_in = w_exp;
      if (state == IDLE) begin
         dec_reg_in = in_regime;
         dec_exp_in = in_exponent + W_EXP'(1);
      end
   end

   posit_exp_dec #(
      .EN    (EN),
      .W_REG (W_REG),
      .W_EXP (W_EXP)
   ) u_exp_dec (
      .regime_in  (dec_reg_in),
      .exp_in     (dec_exp_in),
      .regime_out (dec_reg_out),
      .exp_out    (dec_exp_out),
      .sat        (dec_sat)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = NORM;
         // in NORM the exponent is canonical, so dec_sat means exp==0 at
         // regime minimum: no further shift is representable
         NORM:    if (man_zero || man_norm || dec_sat) state_nxt = DONE;
         DONE:    if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         w_man         <= '0;
         w_reg         <= '0;
         w_exp         <= '0;
         w_neg         <= 1'b0;
         w_zero        <= 1'b0;
         w_uflow       <= 1'b0;
         out_valid     <= 1'b0;
         out_sign      <= POS;
         out_regime    <= '0;
         out_exponent  <= '0;
         out_mantissa  <= '0;
         out_zero      <= 1'b0;
         out_underflow <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  w_man  <= in_mantissa;
                  w_neg  <= in_negate;
                  w_zero <= 1'b0;
                  if (in_exponent[W_EXP-1]) begin
                     w_reg   <= dec_reg_out;
                     w_exp   <= dec_exp_out;
                     w_uflow <= dec_sat;
                  end else begin
                     w_reg   <= in_regime;
                     w_exp   <= in_exponent;
                     w_uflow <= 1'b0;
                  end
               end
            end
            NORM: begin
               if (man_zero) begin
                  // exact zero dominates any earlier saturation
                  w_zero  <= 1'b1;
                  w_uflow <= 1'b0;
                  w_reg   <= '0;
                  w_exp   <= '0;
               end else if (!man_norm) begin
                  if (dec_sat) begin
                     w_uflow <= 1'b1;
                  end else begin
                     w_man <= w_man << 1;
                     w_reg <= dec_reg_out;
                     w_exp <= dec_exp_out;
                  end
               end
            end
            DONE: begin
               // first DONE cycle registers the result; fields then hold
               // until the downstream handshake
               if (!out_valid) begin
                  out_valid     <= 1'b1;
                  out_sign      <= w_neg ? NEG : POS;
                  out_regime    <= w_reg;
                  out_exponent  <= w_exp;
                  out_mantissa  <= w_man;
                  out_zero      <= w_zero;
                  out_underflow <= w_uflow;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
